// File: rtl/addf_serial_ctrl_if.sv
// rtl/addf_serial_ctrl_if.sv - operand/result/adder-cell bundle for addf_serial_ctrl
// Optional OVF signal present when ADDF_SERIAL_OVF_EN is defined.
interface addf_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ci_in;
  logic             add_a;
  logic             add_b;
  logic             add_ci;
  logic             add_sum;
  logic             add_co;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             co_out;
  logic             busy;
`ifdef ADDF_SERIAL_OVF_EN
  logic             ovf;

  // Controller side: takes operands and adder results, drives the cell and the result.
  modport slave (
    input  in_valid, a_in, b_in, ci_in, add_sum, add_co, out_ready,
    output in_ready, add_a, add_b, add_ci, out_valid, sum_out, co_out, busy, ovf
  );

  // Environment side: operand source, result sink and the adder cell.
  modport master (
    output in_valid, a_in, b_in, ci_in, add_sum, add_co, out_ready,
    input  in_ready, add_a, add_b, add_ci, out_valid, sum_out, co_out, busy, ovf
  );
`else
  // Controller side: takes operands and adder results, drives the cell and the result.
  modport slave (
    input  in_valid, a_in, b_in, ci_in, add_sum, add_co, out_ready,
    output in_ready, add_a, add_b, add_ci, out_valid, sum_out, co_out, busy
  );

  // Environment side: operand source, result sink and the adder cell.
  modport master (
    output in_valid, a_in, b_in, ci_in, add_sum, add_co, out_ready,
    input  in_ready, add_a, add_b, add_ci, out_valid, sum_out, co_out, busy
  );
`endif
endinterface

// File: rtl/addf_serial_ctrl.sv
// rtl/addf_serial_ctrl.sv - bit-serial add sequencer driving an external 1-bit full-adder cell
// Optional signed-overflow output enabled by ADDF_SERIAL_OVF_EN.
module addf_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               ck,
  input  logic               rst,
  addf_serial_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             run_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             co_out_q;
`ifdef ADDF_SERIAL_OVF_EN
  logic             ovf_q;
  assign bus.ovf = ovf_q;
`endif

  // Cell inputs come only from registers and are forced low outside RUN.
  assign bus.add_a     = run_q & sha[0];
  assign bus.add_b     = run_q & shb[0];
  assign bus.add_ci    = run_q & carry;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum_out   = sum_out_q;
  assign bus.co_out    = co_out_q;

  // Sequencer: accept operands, feed one bit pair per cycle, present result until taken.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sha         <= '0;
      shb         <= '0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      run_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_out_q   <= '0;
      co_out_q    <= 1'b0;
`ifdef ADDF_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sha        <= bus.a_in;
            shb        <= bus.b_in;
            carry      <= bus.ci_in;
            cnt        <= '0;
            run_q      <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res   <= {bus.add_sum, res[WIDTH-1:1]};
          carry <= bus.add_co;
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB during this last bit.
            sum_out_q   <= {bus.add_sum, res[WIDTH-1:1]};
            co_out_q    <= bus.add_co;
`ifdef ADDF_SERIAL_OVF_EN
            ovf_q       <= carry ^ bus.add_co;
`endif
            run_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          run_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addf_serial_ctrl.sv
// tb/tb_addf_serial_ctrl.sv - randomized self-checking bench for addf_serial_ctrl with a full-adder cell model
module tb_addf_serial_ctrl;
  localparam int W = 8;

  logic ck = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass = 0;

  addf_serial_ctrl_if #(.WIDTH(W)) bus ();

  addf_serial_ctrl #(.WIDTH(W)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // Full-adder cell attached to the controller.
  assign bus.add_sum = bus.add_a ^ bus.add_b ^ bus.add_ci;
  assign bus.add_co  = (bus.add_a & bus.add_b) | (bus.add_a & bus.add_ci) | (bus.add_b & bus.add_ci);

  always #5 ck = ~ck;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction: offer operands, watch the serial run, then hold the result for `hold` cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold);
    longint unsigned full, ea_seq, eci_seq, mask;
    logic [63:0] ci_seq, a_seq;
    int bud, lat, sa, sb, ss;
    bit ok;
    full = longint'(a) + longint'(b) + longint'(ci);
    ea_seq = longint'(a);
    eci_seq = 0;
    for (int i = 0; i < W; i++) begin
      mask = (64'd1 << i) - 1;
      eci_seq |= (((longint'(a) & mask) + (longint'(b) & mask) + longint'(ci)) >> i & 1) << i;
    end
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ss = sa + sb + int'(ci);

    @(negedge ck);
    bus.in_valid = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    bus.ci_in = ci;
    bus.out_ready = 1'b0;
    bud = 0;
    while (!bus.in_ready && bud < 50) begin
      @(negedge ck);
      bud++;
    end
    check("accept_wait", bud < 50, 1);
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    check("run_flags", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);

    lat = 0;
    ci_seq = '0;
    a_seq = '0;
    while (!bus.out_valid && lat < 40) begin
      ci_seq[lat] = bus.add_ci;
      a_seq[lat] = bus.add_a;
      @(posedge ck);
      #1;
      lat++;
    end
    check("latency", lat, W);
    check("add_ci_seq", ci_seq, eci_seq);
    check("add_a_seq", a_seq, ea_seq);
    check("sum_out", bus.sum_out, full & ((64'd1 << W) - 1));
    check("co_out", bus.co_out, (full >> W) & 1);
`ifdef ADDF_SERIAL_OVF_EN
    check("ovf", bus.ovf, (ss > (1 << (W - 1)) - 1 || ss < -(1 << (W - 1))) ? 1 : 0);
`endif
    check("done_cell_idle", {bus.add_a, bus.add_b, bus.add_ci, bus.in_ready}, 4'b0000);

    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a_in = W'($urandom);
      bus.b_in = W'($urandom);
      @(posedge ck);
      #1;
      if (!bus.out_valid || bus.in_ready || !bus.busy ||
          bus.sum_out != W'(full) || bus.co_out != full[W]) ok = 1'b0;
    end
    if (hold > 0) check("hold_stable", ok, 1);

    bus.out_ready = 1'b1;
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("post_handshake", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
    check("sum_kept", {bus.co_out, bus.sum_out}, full & ((64'd1 << (W + 1)) - 1));
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.ci_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check("reset_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("reset_result", {bus.co_out, bus.sum_out}, 0);
    check("reset_cell", {bus.add_a, bus.add_b, bus.add_ci}, 0);
`ifdef ADDF_SERIAL_OVF_EN
    check("reset_ovf", bus.ovf, 0);
`endif
    @(negedge ck);
    rst = 1'b0;

    run_op(8'h35, 8'h0A, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 5);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);

    // Abort mid-run: reset must clear everything immediately.
    @(negedge ck);
    bus.in_valid = 1'b1;
    bus.a_in = 8'hC3;
    bus.b_in = 8'h5A;
    bus.ci_in = 1'b1;
    @(posedge ck);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge ck);
    #2;
    rst = 1'b1;
    #1;
    check("abort_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("abort_result", {bus.co_out, bus.sum_out}, 0);
    check("abort_cell", {bus.add_a, bus.add_b, bus.add_ci}, 0);
    @(negedge ck);
    rst = 1'b0;
    @(posedge ck);
    #1;
    check("abort_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    run_op(8'hC3, 8'h5A, 1'b1, 0);

    for (int i = 0; i < 3; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
